seq_decoder_scan: RTL and testbench
===================================

Name: seq_decoder_scan

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable.
- Successor to the team's combinational 3-to-8 decoder.
- Adds two modes: a registered direct-decode mode, and an auto-scan mode that walks the one-hot output through all lines with a programmable dwell time.
- Intended use: output-line sequencing (LED/display digit scan, chip-select rotation) in the assignment designs.

Parameters:
- SEL_W, 3, select width; derived localparam OUT_W = 2**SEL_W output lines.
- DWELL_W, 8, width of the dwell count (cycles per line minus one).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; 0 forces outputs to zero and aborts a scan
- mode  in  1  0 = direct decode, 1 = scan
- sel  in  SEL_W  decode index (direct mode) or scan start index (scan mode)
- start  in  1  single-cycle pulse that launches or restarts a scan
- dwell  in  DWELL_W  each line is held for dwell+1 cycles; sampled on start
- out  out  OUT_W  registered one-hot output, all-zero when inactive
- idx  out  SEL_W  registered index of the active line
- busy  out  1  high while in SCAN
- wrap  out  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset: out=0, idx=0, busy=0, wrap=0, internal dwell count=0, captured dwell=0, state=IDLE. rst dominates every other input.
- Priority, highest first: rst, then en=0, then mode change, then start, then scan stepping.
- Direct mode (mode=0, state IDLE): 1-cycle latency.
  - out <= en ? onehot(sel) : 0
  - idx <= sel
  - busy=0, wrap=0
  - start is ignored.
- State machine:
  - IDLE -> SCAN when mode=1, en=1 and start=1.
  - SCAN -> IDLE when en=0 or mode=0.
  - In oneshot builds only: SCAN -> IDLE on sweep completion.
- Scan launch (start sampled at edge t), effective edge t+1:
  - idx=sel, out=onehot(sel), busy=1
  - captured dwell <= dwell; count <= dwell
  - wrap=0 on the launch cycle, even if sel=0.
- Scan stepping, each cycle in SCAN:
  - count!=0: count decrements; out and idx hold.
  - count==0: idx <= idx+1 modulo OUT_W; out follows; count reloads from captured dwell.
  - Result: each line is visible for exactly dwell+1 cycles.
- wrap: registered with the output; high for the first cycle on which idx=0 after a 7->0 (OUT_W-1 -> 0) step, otherwise 0.
- start while in SCAN: restarts from the current sel and recaptures dwell; no wrap pulse.
- en=0 in any state: next edge gives out=0, busy=0, wrap=0, state IDLE; idx holds.
  - If start=1 in the same cycle, en wins.
- mode 1->0 during SCAN: next edge returns to IDLE and applies direct decode of sel.
- mode=1 in IDLE without start: out=0, busy=0.
- dwell changes mid-scan have no effect until the next start.

Optional Feature:
- Macro: SEQ_DECODER_SCAN_ONESHOT_EN.
- Defined: a scan performs exactly one sweep of OUT_W lines starting at sel.
  - The sweep ends when the dwell of line (sel-1) mod OUT_W expires.
  - Next edge: IDLE, out=0, busy=0.
  - wrap still pulses if the sweep passes OUT_W-1 -> 0.
- Undefined: the scan runs continuously until en=0, mode=0 or rst.
- Port list is identical in both builds.

Decomposition:
- Package seq_decoder_pkg holds:
  - state encoding (ST_IDLE=1'b0, ST_SCAN=1'b1)
  - mode constants (MODE_DIRECT=0, MODE_SCAN=1)
  - default SEL_W and DWELL_W.
- Sub-module onehot_dec (combinational, parameter SEL_W): index -> OUT_W one-hot. Shared by the direct and scan paths; its output is registered in the parent.

Test Plan (SEL_W=3, DWELL_W=8):
- Reset: rst=1 for 2 cycles with en=1, mode=0, sel=5 -> out=8'h00, idx=0, busy=0, wrap=0. Release rst -> out=8'h20 one cycle later.
- Direct decode: en=1, mode=0, sweep sel 0..7 one per cycle -> out=8'h01, 02, 04 … 80, each one cycle after sel. Then en=0 -> out=8'h00 the next cycle, idx holds 7.
- Scan, dwell=0: mode=1, sel=6, start pulse -> out sequence 8'h40, 80, 01, 02, one per cycle. wrap=1 only on the 8'h01 cycle. busy=1 from the first 8'h40 cycle.
- Scan, dwell=2: sel=0, start -> each one-hot held exactly 3 cycles: 8'h01 x3, 8'h02 x3 … A start mid-scan with sel=4 gives out=8'h10 on the next edge and count reset.
- Abort/reset mid-scan: en=0 while out=8'h08 -> out=0, busy=0 next edge. Same check with rst=1 -> idx=0 as well. en=0 together with start -> remains IDLE.
- Oneshot build (SEQ_DECODER_SCAN_ONESHOT_EN): sel=2, dwell=0, start -> out 8'h04 … 8'h80, 01, 02 (8 cycles), wrap on 8'h01, then out=0, busy=0.

Source files
------------

// File: rtl/seq_decoder_scan_pkg.sv
// Shared types and defaults for the registered one-hot decoder / line scanner.
package seq_decoder_pkg;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_DWELL_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_scan_if.sv
// Control/output bundle of seq_decoder_scan; master drives controls, slave is the decoder.
interface seq_decoder_scan_if
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W
);

    logic                  en;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic                  start;
    logic [DWELL_W-1:0]    dwell;
    logic [2**SEL_W-1:0]   out;
    logic [SEL_W-1:0]      idx;
    logic                  busy;
    logic                  wrap;

    modport master (
        output en, mode, sel, start, dwell,
        input  out, idx, busy, wrap
    );

    modport slave (
        input  en, mode, sel, start, dwell,
        output out, idx, busy, wrap
    );

endinterface

// File: rtl/seq_decoder_scan_onehot_dec.sv
// Combinational index to one-hot decoder shared by the direct and scan paths.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]    idx,
    output logic [2**SEL_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/seq_decoder_scan.sv
// Registered one-hot decoder with direct-decode and auto-scan modes.
// Build option SEQ_DECODER_SCAN_ONESHOT_EN: a scan stops after one full sweep.
module seq_decoder_scan
    import seq_decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input logic               clk,
    input logic               rst,
    seq_decoder_scan_if.slave bus
);

    localparam int OUT_W = 2**SEL_W;

    state_e               state_q, state_d;
    logic [OUT_W-1:0]     out_q, out_d, dec_out;
    logic [SEL_W-1:0]     idx_q, idx_d, idx_inc, dec_idx;
    logic                 busy_q, busy_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   count_q, count_d;
    logic [DWELL_W-1:0]   cap_q, cap_d;
    logic                 stepping, line_done, sweep_done;

`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
    logic [SEL_W-1:0]     first_q, first_d;
`endif

    assign idx_inc   = idx_q + 1'b1;
    assign stepping  = (state_q == ST_SCAN) && bus.en && (bus.mode == MODE_SCAN) && !bus.start;
    assign line_done = (count_q == '0);

`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
    // The sweep is over when the line just before the start line finishes its dwell.
    assign sweep_done = stepping && line_done && (idx_inc == first_q);
`else
    assign sweep_done = 1'b0;
`endif

    assign dec_idx = stepping ? idx_inc : bus.sel;

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .idx    (dec_idx),
        .onehot (dec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            count_q <= '0;
            cap_q   <= '0;
`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
            first_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            count_q <= count_d;
            cap_q   <= cap_d;
`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
            first_q <= first_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.en || bus.mode == MODE_DIRECT) begin
            state_d = ST_IDLE;
        end else if (bus.start) begin
            state_d = ST_SCAN;
        end else if (sweep_done) begin
            state_d = ST_IDLE;
        end
    end

    // Priority: disable, direct decode (also the mode-change exit), start, stepping.
    always_comb begin
        out_d   = out_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        count_d = count_q;
        cap_d   = cap_q;
`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
        first_d = first_q;
`endif
        if (!bus.en) begin
            out_d  = '0;
            busy_d = 1'b0;
        end else if (bus.mode == MODE_DIRECT) begin
            out_d  = dec_out;
            idx_d  = bus.sel;
            busy_d = 1'b0;
        end else if (bus.start) begin
            out_d   = dec_out;
            idx_d   = bus.sel;
            busy_d  = 1'b1;
            count_d = bus.dwell;
            cap_d   = bus.dwell;
`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
            first_d = bus.sel;
`endif
        end else if (state_q == ST_SCAN) begin
            if (sweep_done) begin
                out_d  = '0;
                busy_d = 1'b0;
            end else if (!line_done) begin
                count_d = count_q - 1'b1;
            end else begin
                out_d   = dec_out;
                idx_d   = idx_inc;
                count_d = cap_q;
                wrap_d  = &idx_q;
            end
        end else begin
            out_d  = '0;
            busy_d = 1'b0;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder_scan.sv
// Self-checking bench for seq_decoder_scan (SEL_W=3, DWELL_W=8); table plus scoreboard queue.
module tb_seq_decoder_scan;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic       start;
        logic [2:0] sel;
        logic [7:0] dwell;
        logic [7:0] out;
        logic [2:0] idx;
        logic       chk_idx;
        logic       busy;
        logic       wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    seq_decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) bus ();

    seq_decoder_scan #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    function automatic vec_t mkVec(input logic r, e, m, st, input logic [2:0] sl,
                                   input logic [7:0] dw, input logic [7:0] o,
                                   input logic [2:0] ix, input logic ci, b, w);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.start = st; v.sel = sl; v.dwell = dw;
        v.out = o; v.idx = ix; v.chk_idx = ci; v.busy = b; v.wrap = w;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step_no, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        bus.en    = v.en;
        bus.mode  = v.mode;
        bus.start = v.start;
        bus.sel   = v.sel;
        bus.dwell = v.dwell;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", step_no);
            return;
        end
        e = exp_q.pop_front();
        cmp("out", bus.out, e.out);
        if (e.chk_idx) cmp("idx", {5'd0, bus.idx}, {5'd0, e.idx});
        cmp("busy", {7'd0, bus.busy}, {7'd0, e.busy});
        cmp("wrap", {7'd0, bus.wrap}, {7'd0, e.wrap});
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
        step_no++;
    endtask

    task automatic step(input logic r, e, m, st, input logic [2:0] sl, input logic [7:0] dw,
                        input logic [7:0] o, input logic [2:0] ix, input logic ci, b, w);
        runVec(mkVec(r, e, m, st, sl, dw, o, ix, ci, b, w));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] ix;
        logic [7:0] seq_out[$];

        // rst, en, mode, start, sel, dwell -> out, idx, chk_idx, busy, wrap
        vecs.push_back(mkVec(1, 1, 0, 0, 5, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 1, 0, 0, 5, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 5, 0, 8'h20, 5, 1, 0, 0));
        for (int s = 0; s < 8; s++)
            vecs.push_back(mkVec(0, 1, 0, 1, 3'(s), 0, 8'(1 << s), 3'(s), 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 7, 0, 8'h00, 7, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 3, 0, 8'h00, 7, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 6, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 1, 6, 0, 8'h40, 6, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 6, 0, 8'h80, 7, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 6, 0, 8'h01, 0, 1, 1, 1));
        vecs.push_back(mkVec(0, 1, 1, 0, 6, 0, 8'h02, 1, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 1, 0, 6, 0, 8'h04, 2, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 3, 0, 8'h08, 3, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 3, 0, 8'h08, 3, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

        // dwell=2 from line 0; later dwell input changes must not matter
        step(0, 1, 1, 1, 0, 2, 8'h01, 0, 1, 1, 0);
        seq_out = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04};
        foreach (seq_out[k]) step(0, 1, 1, 0, 0, 0, seq_out[k], 0, 0, 1, 0);
        step(0, 1, 1, 1, 4, 2, 8'h10, 4, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 8'h10, 4, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 8'h10, 4, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 8'h20, 5, 1, 1, 0);

        // wrap pulses only on the first cycle of line 0 when dwell > 0
        step(0, 1, 1, 1, 7, 1, 8'h80, 7, 1, 1, 0);
        step(0, 1, 1, 0, 7, 1, 8'h80, 7, 1, 1, 0);
        step(0, 1, 1, 0, 7, 1, 8'h01, 0, 1, 1, 1);
        step(0, 1, 1, 0, 7, 1, 8'h01, 0, 1, 1, 0);
        step(0, 1, 1, 0, 7, 1, 8'h02, 1, 1, 1, 0);

        // abort with en=0, en=0 beating start, then no self-restart
        step(0, 1, 1, 1, 3, 0, 8'h08, 3, 1, 1, 0);
        step(0, 0, 1, 0, 3, 0, 8'h00, 3, 1, 0, 0);
        step(0, 0, 1, 1, 3, 0, 8'h00, 3, 1, 0, 0);
        step(0, 1, 1, 0, 3, 0, 8'h00, 3, 0, 0, 0);

        // synchronous reset mid-scan
        step(0, 1, 1, 1, 3, 0, 8'h08, 3, 1, 1, 0);
        step(1, 1, 1, 0, 3, 0, 8'h00, 0, 1, 0, 0);
        step(0, 1, 1, 0, 3, 0, 8'h00, 0, 0, 0, 0);

        // sweep from line 2 with dwell 0
        step(0, 1, 1, 1, 2, 0, 8'h04, 2, 1, 1, 0);
        for (int k = 1; k < 8; k++) begin
            ix = 3'(2 + k);
            step(0, 1, 1, 0, 2, 0, 8'(1 << ix), ix, 1, 1, (ix == 3'd0));
        end
`ifdef SEQ_DECODER_SCAN_ONESHOT_EN
        step(0, 1, 1, 0, 2, 0, 8'h00, 0, 0, 0, 0);
        step(0, 1, 1, 0, 2, 0, 8'h00, 0, 0, 0, 0);
`else
        step(0, 1, 1, 0, 2, 0, 8'h04, 2, 1, 1, 0);
        step(0, 1, 1, 0, 2, 0, 8'h08, 3, 1, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
